// File: rtl/dbus_ram_responder.sv
// dbus_ram_responder: single-outstanding data-bus responder backed by a 64-bit strobed RAM
// Ports: clk, resetn (sync active-low); dreq_* request (valid, addr, size, strobe, data);
//        dresp_* response (addr_ok, data_ok, data); err pulses with a rejected data_ok; busy when not IDLE.
module dbus_ram_responder #(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        err,
    output logic        busy
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [3:0]    lat_cnt, lat_cnt_n;
    logic [63:0]   cap_addr, cap_data;
    logic [2:0]    cap_size;
    logic [7:0]    cap_strobe;
    logic [63:0]   a_addr, a_data, off, old_word, merged, resp_word;
    logic [2:0]    a_size, amask;
    logic [7:0]    a_strobe;
    logic [AW-1:0] index;
    logic          ok, access, resp_err;
    logic [63:0]   ram [DEPTH];

    always_comb begin
        state_n   = state;
        lat_cnt_n = lat_cnt;
        case (state)
            IDLE: if (dreq_valid) begin
                state_n   = LATENCY == 0 ? RESP : WAIT;
                lat_cnt_n = LAT_INIT;
            end
            WAIT: if (lat_cnt == 4'd0) state_n = RESP;
                  else lat_cnt_n = lat_cnt - 4'd1;
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY=0 the access happens on the capture edge itself, so the
    // live request is used in IDLE; this feeds only registers, never dresp.
    always_comb begin
        a_addr   = state == IDLE ? dreq_addr : cap_addr;
        a_data   = state == IDLE ? dreq_data : cap_data;
        a_size   = state == IDLE ? dreq_size : cap_size;
        a_strobe = state == IDLE ? dreq_strobe : cap_strobe;
        off      = a_addr - BASE;
        amask    = a_size == 3'd0 ? 3'd0 : a_size == 3'd1 ? 3'd1 : a_size == 3'd2 ? 3'd3 : 3'd7;
        ok       = off < SPAN && (a_addr[2:0] & amask) == 3'd0;
        index    = off[AW+2:3];
        old_word = ram[index];
        merged   = old_word;
        for (int i = 0; i < 8; i++)
            merged[8*i +: 8] = a_strobe[i] ? a_data[8*i +: 8] : old_word[8*i +: 8];
        access   = state != RESP && state_n == RESP;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
        end else begin
            state   <= state_n;
            lat_cnt <= lat_cnt_n;
            if (state == IDLE && dreq_valid) begin
                cap_addr   <= dreq_addr;
                cap_data   <= dreq_data;
                cap_size   <= dreq_size;
                cap_strobe <= dreq_strobe;
            end
            if (access) begin
                resp_word <= ok ? merged : 64'h0;
                resp_err  <= !ok;
            end
        end
    end

    always_ff @(posedge clk)
        if (resetn && access && ok && |a_strobe) ram[index] <= merged;

    always_comb begin
        dresp_addr_ok = state == RESP;
        dresp_data_ok = state == RESP;
        dresp_data    = state == RESP ? resp_word : 64'h0;
        err           = state == RESP && resp_err;
        busy          = state != IDLE;
    end
endmodule
